bus_copy_master: RTL and testbench

Bus initiator that copies a block of words between memory-mapped addresses over the shared ABUS/DBUS/WE peripheral bus. It is the initiator counterpart to the bus's responder devices. After arbitration it drives the address, the write enable and, on writes, the data. Each word is moved as one read cycle followed by one write cycle, and INTR is raised on completion. It sits beside the processor and shares the bus through a request/grant pair.

---
 rtl/bus_copy_master.sv | 143 ++++++++++++++
 tb/tb_bus_copy_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_copy_master.sv
// Bus initiator that copies LEN words from SRC to DST over the shared tri-state
// peripheral bus, one read cycle then one write cycle per word, raising INTR when done.
module bus_copy_master #(
  parameter int BITS   = 32,
  parameter int STRIDE = 4
) (
  input  logic            clk,
  input  logic            init_n,
  input  logic            start,
  input  logic [BITS-1:0] src,
  input  logic [BITS-1:0] dst,
  input  logic [BITS-1:0] len,
  input  logic            abort,
  input  logic            inta,
  input  logic            bus_gnt,
  output logic            bus_req,
  output logic [BITS-1:0] abus,
  inout  wire  [BITS-1:0] dbus,
  output logic            we,
  output logic            busy,
  output logic            intr,
  output logic [BITS-1:0] remain
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_READ  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [BITS-1:0] ZERO_W = {BITS{1'b0}};
  localparam logic [BITS-1:0] ONE_W  = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0] STEP_W = BITS'(STRIDE);
  localparam logic [BITS-1:0] HIZ_W  = {BITS{1'bz}};

  state_t          state_r, state_s;
  logic [BITS-1:0] sa_r, sa_s;
  logic [BITS-1:0] da_r, da_s;
  logic [BITS-1:0] cnt_r, cnt_s;
  logic [BITS-1:0] data_r, data_s;
  logic            intr_r, intr_s;

  // State, address, count, data and interrupt registers.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_r <= S_IDLE;
      sa_r    <= ZERO_W;
      da_r    <= ZERO_W;
      cnt_r   <= ZERO_W;
      data_r  <= ZERO_W;
      intr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sa_r    <= sa_s;
      da_r    <= da_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      intr_r  <= intr_s;
    end
  end

  // Next-state and datapath updates; a set of INTR overrides INTA in the same cycle.
  always_comb begin
    state_s = state_r;
    sa_s    = sa_r;
    da_s    = da_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    if (inta) begin
      intr_s = 1'b0;
    end else begin
      intr_s = intr_r;
    end
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (len != ZERO_W) begin
            sa_s    = src;
            da_s    = dst;
            cnt_s   = len;
            intr_s  = 1'b0;
            state_s = S_REQ;
          end else begin
            intr_s = 1'b1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (bus_gnt) begin
          state_s = S_READ;
        end else begin
          state_s = S_REQ;
        end
      end
      S_READ: begin
        // An aborted read leaves the data register and source pointer untouched.
        if (abort) begin
          state_s = S_IDLE;
        end else begin
          data_s  = dbus;
          sa_s    = sa_r + STEP_W;
          state_s = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write completes on the bus even when aborted, so it is always counted.
        da_s  = da_r + STEP_W;
        cnt_s = cnt_r - ONE_W;
        if (abort) begin
          state_s = S_IDLE;
        end else if (cnt_r == ONE_W) begin
          state_s = S_IDLE;
          intr_s  = 1'b1;
        end else if (bus_gnt) begin
          state_s = S_READ;
        end else begin
          state_s = S_REQ;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  assign bus_req = (state_r != S_IDLE);
  assign busy    = (state_r != S_IDLE);
  assign intr    = intr_r;
  assign remain  = cnt_r;

  // The bus is only driven while this initiator owns a read or write cycle.
  assign abus = (state_r == S_READ)  ? sa_r :
                (state_r == S_WRITE) ? da_r : HIZ_W;
  assign we   = (state_r == S_READ)  ? 1'b0 :
                (state_r == S_WRITE) ? 1'b1 : 1'bz;
  assign dbus = (state_r == S_WRITE) ? data_r : HIZ_W;

endmodule

// File: tb/tb_bus_copy_master.sv
// Self-checking bench for bus_copy_master: a 256-word responder memory, a word-level
// copy model and a per-word bus-cycle schedule derived from the grant pattern.
module tb_bus_copy_master;

  localparam logic [31:0] PA = 32'hC3A5_5A3C;
  localparam logic [31:0] PD = 32'h0F1E_2D3C;

  logic        clk;
  logic        init_n, start, abort, inta, bus_gnt;
  logic        probe, mem_load;
  logic [31:0] src, dst, len;
  wire         bus_req, busy, intr, we;
  wire  [31:0] abus, dbus, remain;

  logic [31:0] mem  [0:255];
  logic [31:0] refm [0:255];
  logic [31:0] exp_remain;
  int          n_tests, n_fail;

  bus_copy_master #(.BITS(32), .STRIDE(4)) dut (
    .clk(clk), .init_n(init_n), .start(start), .src(src), .dst(dst), .len(len),
    .abort(abort), .inta(inta), .bus_gnt(bus_gnt), .bus_req(bus_req), .abus(abus),
    .dbus(dbus), .we(we), .busy(busy), .intr(intr), .remain(remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // When probe is on the bench drives known patterns; they only read back intact if the DUT floats.
  assign abus = probe ? PA : 32'hzzzz_zzzz;
  assign we   = probe ? 1'b0 : 1'bz;
  assign dbus = probe ? PD : ((bus_req && we == 1'b0) ? mem[abus[9:2]] : 32'hzzzz_zzzz);

  function automatic logic [31:0] init_val(input int i);
    return 32'hA000_0000 ^ (32'(i) * 32'h0001_0203) ^ 32'h0000_5A00;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Responder: write port of the memory.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (init_n && !probe && we === 1'b1) begin
      mem[abus[9:2]] <= dbus;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) mism++;
    chk(tag, 32'(mism), 32'd0);
  endtask

  // mode: 0 grant always, 1 grant low for 5 cycles after the first word, 2 random grant.
  // inta_at = -2 means "during the last write cycle".
  task automatic run_copy(input string nm, input logic [31:0] s, input logic [31:0] d,
                          input int l, input int mode, input int abort_at,
                          input int busy_at, input int inta_at);
    bit          g [80];
    int          rc[$], wc[$];
    logic [31:0] vq[$];
    logic [31:0] v;
    int          e, sidx, done, nw, ia;
    logic        exp_intr;
    for (int c = 0; c < 80; c++) begin
      if (mode == 0)      g[c] = 1'b1;
      else if (mode == 1) g[c] = !(c >= 3 && c <= 7);
      else                g[c] = (c >= 40) || ($urandom_range(0, 99) < 60);
    end
    // Each word takes the first grant sampled at or after its request edge: read, then write.
    sidx = 1;
    for (int i = 0; i < l; i++) begin
      e = sidx;
      while (!g[e]) e++;
      rc.push_back(e + 1);
      wc.push_back(e + 2);
      sidx = e + 2;
    end
    done = (l == 0) ? 1 : wc[l-1] + 1;
    exp_intr = 1'b1;
    if (abort_at >= 1 && abort_at < done) begin
      done = abort_at + 1;
      exp_intr = 1'b0;
    end
    ia = (inta_at == -2) ? done - 1 : inta_at;
    nw = 0;
    for (int i = 0; i < l; i++) begin
      if (rc[i] < done) begin
        v = refm[idx(s + 32'd4 * 32'(i))];
        vq.push_back(v);
        if (wc[i] < done) begin
          refm[idx(d + 32'd4 * 32'(i))] = v;
          nw++;
        end
      end
    end
    if (l != 0) exp_remain = 32'(l - nw);
    for (int c = 0; c <= done + 1; c++) begin
      int kind;
      int wi;
      kind = 0;
      wi = 0;
      for (int i = 0; i < rc.size(); i++) begin
        if (rc[i] == c && c < done) begin kind = 1; wi = i; end
        if (wc[i] == c && c < done) begin kind = 2; wi = i; end
      end
      bus_gnt = g[c];
      start   = (c == 0) || (c == busy_at);
      src     = (c == 0) ? s : s ^ 32'h0000_0040;
      dst     = (c == 0) ? d : d ^ 32'h0000_0080;
      len     = (c == 0) ? 32'(l) : 32'(l + 3);
      abort   = (c == abort_at) && (c < done);
      inta    = (c == ia);
      probe   = (kind == 0);
      #1;
      if (c >= 1 && c < done) begin
        chk({nm, ":bus_req"}, {31'd0, bus_req}, 32'd1);
        chk({nm, ":busy"}, {31'd0, busy}, 32'd1);
      end
      if (c == 1 && l != 0) chk({nm, ":intr_clr"}, {31'd0, intr}, 32'd0);
      if (kind == 1) begin
        chk({nm, ":rd_addr"}, abus, s + 32'd4 * 32'(wi));
        chk({nm, ":rd_we"}, {31'd0, we}, 32'd0);
      end else if (kind == 2) begin
        chk({nm, ":wr_addr"}, abus, d + 32'd4 * 32'(wi));
        chk({nm, ":wr_we"}, {31'd0, we}, 32'd1);
        chk({nm, ":wr_data"}, dbus, vq[wi]);
      end else if (c >= 1) begin
        chk({nm, ":hiz_abus"}, abus, PA);
        chk({nm, ":hiz_dbus"}, dbus, PD);
        chk({nm, ":hiz_we"}, {31'd0, we}, 32'd0);
      end
      if (c == done) begin
        chk({nm, ":done_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, ":done_req"}, {31'd0, bus_req}, 32'd0);
        chk({nm, ":done_intr"}, {31'd0, intr}, {31'd0, exp_intr});
        chk({nm, ":remain"}, remain, exp_remain);
      end
      tick();
    end
    start = 1'b0; abort = 1'b0; inta = 1'b0; probe = 1'b0; bus_gnt = 1'b0;
    chk_mem({nm, ":mem"});
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    init_n = 1'b0; start = 1'b0; abort = 1'b0; inta = 1'b0; bus_gnt = 1'b0;
    src = 32'd0; dst = 32'd0; len = 32'd0; probe = 1'b1; mem_load = 1'b1;
    exp_remain = 32'd0;
    for (int i = 0; i < 256; i++) refm[i] = init_val(i);
    #3;
    chk("rst:bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst:busy", {31'd0, busy}, 32'd0);
    chk("rst:intr", {31'd0, intr}, 32'd0);
    chk("rst:remain", remain, 32'd0);
    chk("rst:hiz_abus", abus, PA);
    chk("rst:hiz_dbus", dbus, PD);
    tick();
    mem_load = 1'b0;
    init_n = 1'b1;
    probe = 1'b0;
    tick();

    run_copy("basic", 32'h0000_0100, 32'h0000_0200, 4, 0, -1, -1, -2);
    inta = 1'b1;
    tick();
    inta = 1'b0;
    chk("inta_clr", {31'd0, intr}, 32'd0);

    run_copy("gap", 32'h0000_0040, 32'h0000_0380, 3, 1, -1, -1, -1);
    run_copy("zero", 32'h0000_0010, 32'h0000_0300, 0, 0, -1, -1, -1);
    run_copy("busy_start", 32'h0000_0010, 32'h0000_0090, 3, 0, -1, 3, -1);
    run_copy("abort", 32'h0000_0020, 32'h0000_0320, 5, 0, 7, -1, -1);
    run_copy("wrap", 32'hFFFF_FFFC, 32'h0000_0280, 2, 0, -1, -1, -1);

    for (int k = 0; k < 10; k++) begin
      logic [31:0] rs, rd;
      int ab;
      rs = $urandom() & 32'hFFFF_FFFC;
      rd = $urandom() & 32'hFFFF_FFFC;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_copy("rand", rs, rd, int'($urandom_range(1, 6)), 2, ab, -1, -1);
    end

    // Reset while a read is on the bus: everything floats at once, no clock needed.
    bus_gnt = 1'b1; src = 32'h0000_0060; dst = 32'h0000_03A0; len = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1;
    chk("rstmid:rd_addr", abus, 32'h0000_0060);
    #1;
    init_n = 1'b0;
    probe = 1'b1;
    #1;
    chk("rstmid:bus_req", {31'd0, bus_req}, 32'd0);
    chk("rstmid:busy", {31'd0, busy}, 32'd0);
    chk("rstmid:hiz_abus", abus, PA);
    chk("rstmid:hiz_dbus", dbus, PD);
    chk("rstmid:hiz_we", {31'd0, we}, 32'd0);
    tick();
    init_n = 1'b1;
    tick();
    chk("rstmid:intr", {31'd0, intr}, 32'd0);
    chk("rstmid:remain", remain, 32'd0);
    chk("rstmid:busy_after", {31'd0, busy}, 32'd0);
    probe = 1'b0;
    bus_gnt = 1'b0;
    tick();
    chk_mem("rstmid:mem");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
